// File: rtl/gate_drv_pkg.sv
// Shared types and default constants for the sigma gate driver slice.
package gate_drv_pkg;

  // Gate driver sequencing states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DT_TO_H = 3'd1,
    H_ON    = 3'd2,
    DT_TO_L = 3'd3,
    L_ON    = 3'd4
  } gate_state_t;

  // Recommended power-on programming values for the dead-time and dwell registers
  localparam int DT_DEFAULT    = 8;
  localparam int DWELL_DEFAULT = 50;

endpackage

// File: rtl/sigma_gate_driver_sync_ff.sv
// Parameterized N-stage flop synchronizer with asynchronous active-high reset.
// The reset value is a parameter so the chain can start at the level the
// upstream logic is expected to present after reset.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain, oldest sample at the top
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sigma_gate_driver.sv
// Complementary half-bridge gate driver fed by the hybrid controller's sigma.
// Synchronizes sigma, inserts a programmable dead time between legs, enforces
// a minimum on-time per leg against chattering, and counts leg turn-ons.
module sigma_gate_driver
  import gate_drv_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DT_W        = 8,
  parameter int DWELL_W     = 16,
  parameter int CNT_W       = 16
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic               i_enable,
  input  logic               i_sigma,
  input  logic [DT_W-1:0]    i_deadtime,
  input  logic [DWELL_W-1:0] i_min_dwell,
  output logic               o_gate_H,
  output logic               o_gate_L,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_sw_count
);

  localparam logic [DT_W-1:0]    DT_ONE    = DT_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  gate_state_t        state;
  logic               sigma_s;
  logic               gate_h;
  logic               gate_l;
  logic               busy;
  logic [DT_W-1:0]    dt_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [CNT_W-1:0]   sw_count;
  logic [DT_W-1:0]    dt_load;

  // The controller starts with sigma high, so the synchronizer resets to 1
  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sigma_sync (
    .clock (i_clock),
    .reset (i_RESET),
    .d     (i_sigma),
    .q     (sigma_s)
  );

  // A zero dead time is clamped to one cycle so the legs never switch together
  always_comb begin
    dt_load = i_deadtime;
    if (i_deadtime == '0) begin
      dt_load = DT_ONE;
    end
  end

  // Leg sequencing FSM with dead-time, dwell and event counters, all outputs registered
  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      state     <= IDLE;
      gate_h    <= 1'b0;
      gate_l    <= 1'b0;
      busy      <= 1'b0;
      dt_cnt    <= '0;
      dwell_cnt <= '0;
      sw_count  <= '0;
    end else if (!i_enable) begin
      state     <= IDLE;
      gate_h    <= 1'b0;
      gate_l    <= 1'b0;
      busy      <= 1'b0;
      dt_cnt    <= '0;
      dwell_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          gate_h <= 1'b0;
          gate_l <= 1'b0;
          busy   <= 1'b1;
          dt_cnt <= dt_load;
          if (sigma_s) begin
            state <= DT_TO_H;
          end else begin
            state <= DT_TO_L;
          end
        end

        DT_TO_H: begin
          if (dt_cnt <= DT_ONE) begin
            state     <= H_ON;
            gate_h    <= 1'b1;
            gate_l    <= 1'b0;
            busy      <= 1'b0;
            dt_cnt    <= '0;
            dwell_cnt <= i_min_dwell;
            sw_count  <= sw_count + CNT_ONE;
          end else begin
            dt_cnt <= dt_cnt - DT_ONE;
          end
        end

        DT_TO_L: begin
          if (dt_cnt <= DT_ONE) begin
            state     <= L_ON;
            gate_h    <= 1'b0;
            gate_l    <= 1'b1;
            busy      <= 1'b0;
            dt_cnt    <= '0;
            dwell_cnt <= i_min_dwell;
            sw_count  <= sw_count + CNT_ONE;
          end else begin
            dt_cnt <= dt_cnt - DT_ONE;
          end
        end

        H_ON: begin
          if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - DWELL_ONE;
          end
          if ((dwell_cnt == '0) && !sigma_s) begin
            state  <= DT_TO_L;
            gate_h <= 1'b0;
            busy   <= 1'b1;
            dt_cnt <= dt_load;
          end
        end

        L_ON: begin
          if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - DWELL_ONE;
          end
          if ((dwell_cnt == '0) && sigma_s) begin
            state  <= DT_TO_H;
            gate_l <= 1'b0;
            busy   <= 1'b1;
            dt_cnt <= dt_load;
          end
        end

        default: begin
          state     <= IDLE;
          gate_h    <= 1'b0;
          gate_l    <= 1'b0;
          busy      <= 1'b0;
          dt_cnt    <= '0;
          dwell_cnt <= '0;
        end
      endcase
    end
  end

  assign o_gate_H   = gate_h;
  assign o_gate_L   = gate_l;
  assign o_busy     = busy;
  assign o_sw_count = sw_count;

endmodule

// File: tb/tb_sigma_gate_driver.sv
// Directed self-checking bench for sigma_gate_driver.
// The event counter is built 8 bits wide here so a full counter wrap fits in
// a short run; every other width keeps its default.
module tb_sigma_gate_driver;
  import gate_drv_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int DT_W        = 8;
  localparam int DWELL_W     = 16;
  localparam int CNT_W       = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               sigma;
  logic [DT_W-1:0]    deadtime;
  logic [DWELL_W-1:0] min_dwell;
  logic               gate_h;
  logic               gate_l;
  logic               busy;
  logic [CNT_W-1:0]   sw_count;

  int checks = 0;
  int errors = 0;

  sigma_gate_driver #(
    .SYNC_STAGES (SYNC_STAGES),
    .DT_W        (DT_W),
    .DWELL_W     (DWELL_W),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clock     (clock),
    .i_RESET     (reset),
    .i_enable    (enable),
    .i_sigma     (sigma),
    .i_deadtime  (deadtime),
    .i_min_dwell (min_dwell),
    .o_gate_H    (gate_h),
    .o_gate_L    (gate_l),
    .o_busy      (busy),
    .o_sw_count  (sw_count)
  );

  // 10 ns system clock
  always #5 clock = ~clock;

  // The two gates must never be on together, checked every falling edge
  always @(negedge clock) begin
    checks++;
    assert (!(gate_h && gate_l)) else begin
      errors++;
      $error("[TB] FAIL overlap: observed H=%0b L=%0b, expected never both 1", gate_h, gate_l);
    end
  end

  task automatic applyStimulus(input logic rst, input logic en, input logic sig,
                               input logic [DT_W-1:0] dt, input logic [DWELL_W-1:0] dwell);
    reset     = rst;
    enable    = en;
    sigma     = sig;
    deadtime  = dt;
    min_dwell = dwell;
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic exp_h, input logic exp_l,
                             input logic exp_busy, input logic [CNT_W-1:0] exp_cnt);
    logic [CNT_W+2:0] observed;
    logic [CNT_W+2:0] expected;
    observed = {gate_h, gate_l, busy, sw_count};
    expected = {exp_h, exp_l, exp_busy, exp_cnt};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed H=%0b L=%0b busy=%0b cnt=%0d, expected H=%0b L=%0b busy=%0b cnt=%0d",
             tag, gate_h, gate_l, busy, sw_count, exp_h, exp_l, exp_busy, exp_cnt);
    end
  endtask

  initial begin
    logic sig_now;

    // Start-up: reset held for 5 cycles with dead time 5
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd5, 16'd0);
    for (int i = 0; i < 5; i++) begin
      stepCycles(1);
      checkOutput("in_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd5, 16'd0);
    stepCycles(1);
    checkOutput("startup_dt_first", 1'b0, 1'b0, 1'b1, 8'd0);
    stepCycles(4);
    checkOutput("startup_dt_last", 1'b0, 1'b0, 1'b1, 8'd0);
    stepCycles(1);
    checkOutput("startup_h_on", 1'b1, 1'b0, 1'b0, 8'd1);

    // Single toggle H -> L with dead time 5
    $display("[TB] single toggle");
    sigma = 1'b0;
    stepCycles(2);
    checkOutput("toggle_h_held", 1'b1, 1'b0, 1'b0, 8'd1);
    stepCycles(1);
    checkOutput("toggle_h_off", 1'b0, 1'b0, 1'b1, 8'd1);
    stepCycles(4);
    checkOutput("toggle_dt_last", 1'b0, 1'b0, 1'b1, 8'd1);
    stepCycles(1);
    checkOutput("toggle_l_on", 1'b0, 1'b1, 1'b0, 8'd2);

    // Back to H with a 100-cycle minimum dwell, then chatter on sigma
    $display("[TB] chatter rejection");
    sigma     = 1'b1;
    min_dwell = 16'd100;
    stepCycles(8);
    checkOutput("dwell_h_on", 1'b1, 1'b0, 1'b0, 8'd3);
    stepCycles(20);
    sigma = 1'b0;
    stepCycles(3);
    sigma = 1'b1;
    checkOutput("chatter_during", 1'b1, 1'b0, 1'b0, 8'd3);
    stepCycles(10);
    checkOutput("chatter_after", 1'b1, 1'b0, 1'b0, 8'd3);

    // A held request is honored only once the dwell has run out
    sigma = 1'b0;
    stepCycles(67);
    checkOutput("dwell_last_cycle", 1'b1, 1'b0, 1'b0, 8'd3);
    stepCycles(1);
    checkOutput("dwell_expired", 1'b0, 1'b0, 1'b1, 8'd3);
    min_dwell = 16'd0;
    stepCycles(5);
    checkOutput("dwell_l_on", 1'b0, 1'b1, 1'b0, 8'd4);

    // Zero dead time is clamped to a single gap cycle
    $display("[TB] zero dead time");
    deadtime = 8'd0;
    sigma    = 1'b1;
    stepCycles(2);
    checkOutput("zdt_l_held", 1'b0, 1'b1, 1'b0, 8'd4);
    stepCycles(1);
    checkOutput("zdt_gap", 1'b0, 1'b0, 1'b1, 8'd4);
    stepCycles(1);
    checkOutput("zdt_h_on", 1'b1, 1'b0, 1'b0, 8'd5);

    // Enable dropped in the middle of DT_TO_L
    $display("[TB] enable drop");
    deadtime = 8'd5;
    sigma    = 1'b0;
    stepCycles(3);
    checkOutput("en_dt_entry", 1'b0, 1'b0, 1'b1, 8'd5);
    stepCycles(2);
    enable = 1'b0;
    stepCycles(1);
    checkOutput("en_off_idle", 1'b0, 1'b0, 1'b0, 8'd5);
    stepCycles(2);
    checkOutput("en_off_hold", 1'b0, 1'b0, 1'b0, 8'd5);
    enable = 1'b1;
    stepCycles(5);
    checkOutput("reen_dt_last", 1'b0, 1'b0, 1'b1, 8'd5);
    stepCycles(1);
    checkOutput("reen_l_on", 1'b0, 1'b1, 1'b0, 8'd6);

    // Asynchronous reset mid-dwell, then restart for the wrap run
    $display("[TB] async reset and counter wrap");
    stepCycles(3);
    reset = 1'b1;
    #2;
    checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    stepCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd1, 16'd0);
    stepCycles(2);
    checkOutput("wrap_start", 1'b1, 1'b0, 1'b0, 8'd1);

    // 256 toggles with dead time 1 bring the 8-bit counter back to 1
    sig_now = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sig_now = ~sig_now;
      sigma   = sig_now;
      stepCycles(4);
      checkOutput("wrap_toggle", (i % 2) == 1, (i % 2) == 0, 1'b0, 8'(i + 2));
    end
    checkOutput("wrap_end", 1'b1, 1'b0, 1'b0, 8'd1);

    // Default programming values after a fresh reset
    $display("[TB] default settings");
    reset = 1'b1;
    #2;
    checkOutput("reset_again", 1'b0, 1'b0, 1'b0, 8'd0);
    stepCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'(DT_DEFAULT), 16'(DWELL_DEFAULT));
    stepCycles(8);
    checkOutput("default_dt_last", 1'b0, 1'b0, 1'b1, 8'd0);
    stepCycles(1);
    checkOutput("default_h_on", 1'b1, 1'b0, 1'b0, 8'd1);
    sigma = 1'b0;
    stepCycles(10);
    checkOutput("default_dwell_hold", 1'b1, 1'b0, 1'b0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigma_gate_driver.md
# sigma_gate_driver

Converts the single switching variable `o_sigma` produced by the hybrid controller into complementary high-side and low-side gate commands for the resonant converter half-bridge. It adds a 2-flop input synchronizer, runtime-programmable dead time, and minimum-dwell anti-chattering. It also provides a switching-event counter for debug. The block sits directly downstream of the hybrid control stage and drives the FPGA gate-driver pins.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `i_sigma`; legal 1..3.
- `DT_W`, 8: width of dead-time count.
- `DWELL_W`, 16: width of minimum-dwell count.
- `CNT_W`, 16: width of switching-event counter.
- `i_clock`  in  1  single system clock.
- `i_RESET`  in  1  reset, asynchronous, active-high.
- `i_enable`  in  1  bridge enable; low forces both gates off.
- `i_sigma`  in  1  switching request (1 = high side on, 0 = low side on).
- `i_deadtime`  in  DT_W  dead time in clock cycles (unsigned).
- `i_min_dwell`  in  DWELL_W  minimum on-time of a leg in cycles (unsigned).
- `o_gate_H`  out  1  high-side gate command; reset 0.
- `o_gate_L`  out  1  low-side gate command; reset 0.
- `o_busy`  out  1  1 while in a dead-time state; reset 0.
- `o_sw_count`  out  CNT_W  number of completed leg turn-ons, wraps; reset 0.

## Operation
- `i_sigma` passes through `SYNC_STAGES` flops to give `sigma_s`. Reset value of every synchronizer flop is 1, matching the controller's initial sigma.
- FSM states: IDLE, DT_TO_H, H_ON, DT_TO_L, L_ON. Reset state is IDLE. All outputs are registered.
- IDLE: both gates 0.
  - With `i_enable`=1, go to DT_TO_H if `sigma_s`=1, else DT_TO_L.
  - On entry, load the dead-time counter with `max(i_deadtime,1)`.
- DT_TO_x: both gates 0 and `o_busy`=1. The counter decrements each cycle.
  - At counter==1, go to x_ON.
  - On entry to x_ON: assert the target gate, load the dwell counter with `i_min_dwell`, and increment `o_sw_count` (wraps from all-ones to 0).
- H_ON / L_ON: the dwell counter decrements to 0 and saturates there.
  - Leave only when dwell==0 and `sigma_s` requests the opposite leg.
  - On leaving, the active gate drops and the FSM enters the opposite DT state. `i_deadtime` is sampled on that edge.
  - A `sigma_s` pulse that returns before dwell expires is ignored. Only the level present once dwell==0 matters.
- `i_deadtime` and `i_min_dwell` are sampled only at counter load. Changes mid-interval have no effect until the next load.
- `i_deadtime`=0 is clamped to 1. The gates never overlap and are never switched in the same cycle.
- `i_min_dwell`=0 means no dwell restriction.
- `i_enable`=0 in any state: next edge both gates 0, FSM goes to IDLE, counters are cleared. `o_sw_count` is held.
- Invariant: `o_gate_H & o_gate_L` is never 1.

## Timing
- Request latency: `i_sigma` changing before edge k is seen as `sigma_s` at edge k+SYNC_STAGES-1. The gate decision is made at edge k+SYNC_STAGES.
- Turn-off: the active gate falls at edge k+SYNC_STAGES, provided dwell==0.
- Turn-on: the opposite gate rises exactly `max(i_deadtime,1)` cycles after the falling edge of the other gate.
- Enable path: `i_enable` is not synchronized (internal signal). Gates fall 1 cycle after `i_enable` is low.
  - From IDLE with `i_enable`=1, the first gate rises after 1 + `max(i_deadtime,1)` cycles.
- Reset: asynchronous assertion forces both gates to 0 immediately and clears all state. Release is synchronous to `i_clock`.
- Reset mid-dead-time or mid-dwell restarts from IDLE.

## Structure
- Shared package `gate_drv_pkg`: FSM state enum (`IDLE`, `DT_TO_H`, `H_ON`, `DT_TO_L`, `L_ON`) and default constants (`DT_DEFAULT`=8, `DWELL_DEFAULT`=50).
- One sub-module, `sync_ff`: parameterized N-stage synchronizer with async active-high reset and a reset-value parameter.
- Everything else lives in `sigma_gate_driver`: FSM, dead-time counter, dwell counter, event counter.

## Test plan
- Reset/start-up: `i_RESET`=1 for 5 cycles, `i_enable`=1, `i_sigma`=1, `i_deadtime`=5. Expect both gates 0 during reset and `o_gate_H`=1 exactly 6 cycles after release, with `o_sw_count`=1.
- Single toggle: in H_ON with dwell expired, drop `i_sigma`.
  - `o_gate_H` falls 2 cycles later.
  - `o_gate_L` rises 5 cycles after that.
  - `o_busy`=1 for those 5 cycles.
  - `o_sw_count`=2.
- Chatter: `i_min_dwell`=100; pulse `i_sigma` low for 3 cycles, 20 cycles after H turn-on. Expect no gate change and `o_sw_count` unchanged.
- Zero dead time: `i_deadtime`=0 and toggle. Expect exactly 1 cycle with both gates 0, never overlap.
- Enable drop mid-DT_TO_L: `i_enable`=0. Expect both gates 0 next cycle and IDLE. Re-enable with `i_sigma`=0: L rises after 1+DT cycles.
- Wrap/invariant: preload-free run of 65536 toggles with `i_deadtime`=1, `i_min_dwell`=0. Expect `o_sw_count` back to 1 (one start-up turn-on plus 65536 toggles ≡ 1 mod 2^16). An assertion must show `o_gate_H & o_gate_L` is never 1.
